// File: rtl/hdmi_pattern_gen.sv
// Video timing generator with four selectable test patterns (bars, grid, ramp, scrolling ramp).
// Counters run one cycle ahead of the registered HDMI outputs; patterns switch only at pixel (0,0).
module hdmi_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] hdmi_d,
    output logic        hdmi_de,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [31:0]   H_ACT    = 32'(H_ACTIVE);
    localparam logic [31:0]   V_ACT    = 32'(V_ACTIVE);
    localparam logic [31:0]   HS_BEG   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0]   HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0]   VS_BEG   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0]   VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {S_HOLD, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pat_q, pat_d;
    logic [7:0]    frm_cnt_q, frm_cnt_d;
    logic [7:0]    frm_use_q, frm_use_d;
    logic [23:0]   d_q, d_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

    logic          first, active, run;
    logic [1:0]    pat_eff;
    logic [7:0]    frm_eff, h8, ramp;
    logic [5:0]    h6, v6;
    logic [23:0]   pix, bar_rgb;

    always_comb begin
        run     = (state_q == S_RUN);
        state_d = S_RUN;
        first   = (h_cnt_q == '0) && (v_cnt_q == '0);
        active  = (32'(h_cnt_q) < H_ACT) && (32'(v_cnt_q) < V_ACT);
        h8      = 8'(h_cnt_q);
        h6      = 6'(h_cnt_q);
        v6      = 6'(v_cnt_q);

        // At pixel (0,0) the new frame's pattern and frame number are used before they are registered
        pat_eff = first ? pattern_sel : pat_q;
        frm_eff = first ? frm_cnt_q : frm_use_q;
        ramp    = h8 + frm_eff;

        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        frm_cnt_d = frm_cnt_q;
        frm_use_d = frm_use_q;

        if (run) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d   = '0;
                v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + BW'(1);
                end
            end
            if (first) begin
                pat_d     = pattern_sel;
                frm_use_d = frm_cnt_q;
                frm_cnt_d = frm_cnt_q + 8'd1;
            end
        end

        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        case (pat_eff)
            2'd0:    pix = bar_rgb;
            2'd1:    pix = ((h6 == '0) || (v6 == '0)) ? '1 : '0;
            2'd2:    pix = {h8, h8, h8};
            default: pix = {ramp, ramp, ramp};
        endcase

        d_d  = '0;
        de_d = 1'b0;
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        fs_d = 1'b0;
        if (run) begin
            d_d  = active ? pix : '0;
            de_d = active;
            hs_d = ((32'(h_cnt_q) >= HS_BEG) && (32'(h_cnt_q) < HS_END)) ? HS_POL : ~HS_POL;
            vs_d = ((32'(v_cnt_q) >= VS_BEG) && (32'(v_cnt_q) < VS_END)) ? VS_POL : ~VS_POL;
            fs_d = first;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            frm_cnt_q <= '0;
            frm_use_q <= '0;
            d_q       <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            frm_cnt_q <= frm_cnt_d;
            frm_use_q <= frm_use_d;
            d_q       <= d_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
        end
    end

    assign hdmi_d      = d_q;
    assign hdmi_de     = de_q;
    assign hdmi_hs     = hs_q;
    assign hdmi_vs     = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen at small timing: a frame-position reference model checks every
// output cycle, plus directed checks of reset, line/frame timing, bars, switching and scroll wrap.
module tb_hdmi_pattern_gen;

    localparam int HT = 24;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] hdmi_d;
    logic        hdmi_de, hdmi_hs, hdmi_vs, frame_start;

    int unsigned total = 0;
    int unsigned bad = 0;

    hdmi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_pix(clk), .rst_n(rst_n), .pattern_sel(pattern_sel),
        .hdmi_d(hdmi_d), .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs),
        .hdmi_vs(hdmi_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bar_colour(input int unsigned i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] grey(input int unsigned x);
        logic [7:0] g;
        g = 8'(x % 256);
        return {g, g, g};
    endfunction

    // Reference model: output cycle t since restart maps to frame t/FT and pixel (t%HT, (t/HT)%VT)
    logic [27:0] exp_v;
    bit          m_run = 1'b0;
    int unsigned m_t, m_frm, mp, mh, mv;
    logic [1:0]  m_pat;
    logic [23:0] m_pix;
    logic        m_act;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 1'b0;
            exp_v = '0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            exp_v = '0;
        end else begin
            mp = m_t % FT;
            mh = mp % HT;
            mv = mp / HT;
            if (mp == 0) begin
                m_pat = pattern_sel;
                m_frm = (m_t / FT) % 256;
            end
            m_act = (mh < 16) && (mv < 4);
            case (m_pat)
                2'd0: m_pix = bar_colour(mh / 2);
                2'd1: m_pix = ((mh % 64 == 0) || (mv % 64 == 0)) ? 24'hFFFFFF : 24'h000000;
                2'd2: m_pix = grey(mh);
                default: m_pix = grey(mh + m_frm);
            endcase
            exp_v = {m_act ? m_pix : 24'h0, m_act, (mh >= 18 && mh < 21),
                     (mv >= 5 && mv < 7), (mp == 0)};
            m_t++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model", {4'h0, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start}, {4'h0, exp_v});
    endtask

    task automatic wait_fs();
        int unsigned n = 0;
        while (frame_start !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("fs_timeout", 32'(n < 400), 32'd1);
    endtask

    logic [27:0] cap [FT];

    task automatic capture_frame();
        for (int i = 0; i < FT; i++) begin
            cap[i] = {hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start};
            if (i < FT - 1) tick();
        end
    endtask

    task automatic check_line0_bars(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk(tag, {8'h0, hdmi_d}, {8'h0, bar_colour(32'(i) / 2)});
            tick();
        end
    endtask

    initial begin
        int unsigned de_cnt, de_low, hs_first, hs_cnt, vs_first, vs_cnt;
        logic [23:0] blank_or;
        logic [7:0]  kb;

        // Reset and first frame
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_vals", {4'h0, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start}, 32'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("fs_edge1", {31'h0, frame_start}, 32'd0);
        tick();
        chk("fs_edge2", {31'h0, frame_start}, 32'd1);
        chk("de_edge2", {31'h0, hdmi_de}, 32'd1);
        capture_frame();
        tick();
        chk("fs_period", {31'h0, frame_start}, 32'd1);

        // Line and frame timing from the captured bar frame
        de_cnt = 0; de_low = 99; hs_first = 99; hs_cnt = 0; vs_first = 999; vs_cnt = 0;
        blank_or = '0;
        for (int i = 0; i < FT; i++) begin
            if (i < HT) begin
                if (cap[i][3]) de_cnt++;
                else if (de_low == 99) de_low = i;
                if (cap[i][2]) begin
                    hs_cnt++;
                    if (hs_first == 99) hs_first = i;
                end
            end
            if (cap[i][1]) begin
                vs_cnt++;
                if (vs_first == 999) vs_first = i;
            end
            if (!cap[i][3]) blank_or = blank_or | cap[i][27:4];
        end
        chk("de_high_cycles", de_cnt, 32'd16);
        chk("de_fall_pos", de_low, 32'd16);
        chk("hs_rise_pos", hs_first, 32'd18);
        chk("hs_width", hs_cnt, 32'd3);
        chk("vs_rise_pos", vs_first, 32'd120);
        chk("vs_width", vs_cnt, 32'd48);
        chk("blank_data", {8'h0, blank_or}, 32'h0);
        for (int i = 0; i < 16; i++)
            chk("bars_line0", {8'h0, cap[i][27:4]}, {8'h0, bar_colour(32'(i) / 2)});

        // Frame-aligned switch at line 1 pixel 5 of the current frame
        repeat (HT + 5) tick();
        pattern_sel = 2'd2;
        tick();
        wait_fs();
        for (int i = 0; i < 16; i++) begin
            chk("ramp_line0", {8'h0, hdmi_d}, {8'h0, grey(i)});
            tick();
        end

        // Random mid-frame pattern changes against the model
        for (int i = 0; i < 6 * FT; i++) begin
            tick();
            if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
        end

        // Scroll wrap over 257 frames from a fresh reset
        pattern_sel = 2'd3;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 257; k++) begin
            kb = 8'(k);
            chk("scroll_px0_fs", {31'h0, frame_start}, 32'd1);
            chk("scroll_px0", {8'h0, hdmi_d}, {8'h0, kb, kb, kb});
            if (k < 256) begin
                tick();
                wait_fs();
            end
        end

        // Mid-frame reset while vs is high
        begin
            int unsigned n = 0;
            while (hdmi_vs !== 1'b1 && n < 400) begin
                tick();
                n++;
            end
            chk("vs_found", 32'(n < 400), 32'd1);
        end
        pattern_sel = 2'd0;
        rst_n = 1'b0;
        tick();
        chk("vs_drop", {31'h0, hdmi_vs}, 32'd0);
        chk("reset_mid", {4'h0, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs, frame_start}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("restart_edge1", {31'h0, frame_start}, 32'd0);
        tick();
        chk("restart_edge2", {31'h0, frame_start}, 32'd1);
        check_line0_bars("restart_bars");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
